// File: rtl/bram_initiator_if.sv
// Request/response handshake and block-RAM port bundle for bram_initiator.
// The slave modport is the initiator's view; master is the surrounding environment.
interface bram_initiator_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_L = 4
);
  localparam int DATA_W = DATA_L * 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_L-1:0] req_sel;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_w;
  logic              mem_we;
  logic [DATA_L-1:0] mem_sel;
  logic              mem_en;
  logic [DATA_W-1:0] mem_data_r;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_sel,
    output req_ready,
    output rsp_valid, rsp_rdata,
    input  rsp_ready,
    output mem_addr, mem_data_w, mem_we, mem_sel, mem_en,
    input  mem_data_r
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_sel,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    output rsp_ready,
    input  mem_addr, mem_data_w, mem_we, mem_sel, mem_en,
    output mem_data_r
  );
endinterface

// File: rtl/bram_initiator.sv
// Block-RAM initiator: issues upstream requests straight to the RAM port and
// returns one response per request through a 2-entry skid buffer with read-data bypass.
module bram_initiator #(
  parameter int ADDR_W = 14,
  parameter int DATA_L = 4
) (
  input  logic           clk,
  input  logic           rst,
  bram_initiator_if.slave bus
);
  localparam int DATA_W = DATA_L * 8;

  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];

  logic              req_ready;
  logic              accept;
  logic              rsp_valid;
  logic              pop;
  logic              pop_buf;
  logic              capture;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    // Ready counts buffered plus in-flight responses so a capture can never overflow.
    req_ready  = !rst && ((occ_q == 2'd0) || ((occ_q == 2'd1) && !inflight_q));
    accept     = bus.req_valid && req_ready;
    rsp_valid  = (occ_q != 2'd0) || inflight_q;
    pop        = rsp_valid && bus.rsp_ready;
    pop_buf    = pop && (occ_q != 2'd0);
    capture    = inflight_q && !(pop && (occ_q == 2'd0));
    inflight_d = accept;

    buf_d = buf_q;
    occ_d = occ_q;
    if (pop_buf) begin
      buf_d[0] = buf_q[1];
      occ_d    = occ_q - 2'd1;
    end
    // A capture lands behind whatever remains after this cycle's pop.
    if (capture) begin
      buf_d[occ_d[0]] = bus.mem_data_r;
      occ_d           = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf_q      <= buf_d;
    end
  end

  assign addr           = bus.req_addr;
  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_rdata  = (occ_q != 2'd0) ? buf_q[0] : bus.mem_data_r;
  assign bus.mem_en     = accept;
  assign bus.mem_addr   = addr;
  assign bus.mem_data_w = bus.req_wdata;
  assign bus.mem_we     = bus.req_we;
  assign bus.mem_sel    = bus.req_sel;
endmodule

// File: tb/tb_bram_initiator.sv
// Bench for bram_initiator: behavioural RAM, response scoreboard queue and
// directed plus randomized scenarios.
module tb_bram_initiator;
  localparam int ADDR_W = 14;
  localparam int DATA_L = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_initiator_if #(.ADDR_W(ADDR_W), .DATA_L(DATA_L)) bus ();
  bram_initiator #(.ADDR_W(ADDR_W), .DATA_L(DATA_L)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // RAM with registered read-before-write output
  logic [31:0] ram [0:DEPTH-1];
  logic [31:0] ram_rd = '0;
  assign bus.mem_data_r = ram_rd;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      ram_rd <= ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] <= merge(ram[bus.mem_addr], bus.mem_data_w, bus.mem_sel);
    end
  end

  // reference: word contents and queue of responses owed, oldest first
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  logic        s_acc, s_pop, s_ready, s_valid, s_under;
  logic [31:0] s_got, s_exp;
  int          s_out;

  task automatic set_req(input logic v, input logic we, input logic [13:0] a,
                         input logic [31:0] d, input logic [3:0] sel);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_sel   = sel;
  endtask

  // Called at a negedge: observe just before the next rising edge, update model, return at next negedge.
  task automatic step();
    #4;
    s_out   = exp_q.size();
    s_ready = bus.req_ready;
    s_valid = bus.rsp_valid;
    s_acc   = bus.req_valid && bus.req_ready;
    s_pop   = bus.rsp_valid && bus.rsp_ready;
    s_got   = bus.rsp_rdata;
    s_exp   = 'x;
    s_under = 1'b0;
    if (s_pop) begin
      if (exp_q.size() == 0) s_under = 1'b1;
      else s_exp = exp_q.pop_front();
    end
    if (s_acc) begin
      exp_q.push_back(ref_mem[bus.req_addr]);
      if (bus.req_we) ref_mem[bus.req_addr] = merge(ref_mem[bus.req_addr], bus.req_wdata, bus.req_sel);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_req(1'b1, 1'b0, 14'd0, 32'd0, 4'h0);
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #4;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
    @(negedge clk);
    rst = 1'b0;
    set_req(1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
    step();
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b expected 1", s_ready); end
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b expected 0", s_valid); end
  endtask

  task automatic test_write_read();
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 1'b1, 14'h0005, 32'hDEADBEEF, 4'hF);
    step();
    n_cmp++; if (s_acc !== 1'b1) begin n_err++; $display("FAIL wr_accept: got %b expected 1", s_acc); end
    set_req(1'b1, 1'b0, 14'h0005, 32'h0, 4'h0);
    step();
    n_cmp++; if (s_acc !== 1'b1) begin n_err++; $display("FAIL rd_accept: got %b expected 1", s_acc); end
    n_cmp++; if (!s_pop || s_under || s_got !== s_exp) begin n_err++; $display("FAIL wr_response: got %h pop %b expected %h", s_got, s_pop, s_exp); end
    set_req(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    step();
    n_cmp++; if (s_pop !== 1'b1 || s_got !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_latency_data: got %h pop %b expected deadbeef pop 1", s_got, s_pop); end
  endtask

  task automatic test_partial_write();
    logic [31:0] want [5];
    logic        we_t [6];
    logic [31:0] d_t  [6];
    logic [3:0]  sel_t[6];
    want = '{32'h11223344, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h0};
    we_t = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    d_t  = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    sel_t = '{4'hF, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_req((c < 5), we_t[c], 14'd9, d_t[c], sel_t[c]);
      step();
      if (c < 5) begin
        n_cmp++; if (s_acc !== 1'b1) begin n_err++; $display("FAIL partial_accept[%0d]: got %b expected 1", c, s_acc); end
      end
      if (c >= 2) begin
        n_cmp++; if (s_pop !== 1'b1 || s_got !== want[c-2]) begin n_err++; $display("FAIL partial_rsp[%0d]: got %h expected %h", c, s_got, want[c-2]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] addrs [3];
    int idx;
    logic [31:0] hold_v;
    addrs = '{14'd1, 14'd2, 14'd3};
    idx = 0;
    hold_v = '0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_req(1'b1, 1'b0, addrs[idx], 32'h0, 4'h0);
      step();
      if (s_acc) idx++;
      n_cmp++; if (s_ready !== (c < 2)) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, s_ready, (c < 2)); end
      if (c == 1) hold_v = s_got;
      if (c >= 2) begin
        n_cmp++; if (s_got !== hold_v || s_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got %h valid %b expected %h valid 1", c, s_got, s_valid, hold_v); end
      end
    end
    n_cmp++; if (idx != 2) begin n_err++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
    bus.rsp_ready = 1'b1;
    step();
    n_cmp++; if (!s_pop || s_acc || s_got !== ref_mem[1]) begin n_err++; $display("FAIL bp_rel1: got %h pop %b acc %b expected %h pop 1 acc 0", s_got, s_pop, s_acc, ref_mem[1]); end
    step();
    n_cmp++; if (!s_pop || !s_acc || s_got !== ref_mem[2]) begin n_err++; $display("FAIL bp_rel2: got %h pop %b acc %b expected %h pop 1 acc 1", s_got, s_pop, s_acc, ref_mem[2]); end
    set_req(1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    step();
    n_cmp++; if (!s_pop || s_got !== ref_mem[3]) begin n_err++; $display("FAIL bp_rel3: got %h pop %b expected %h pop 1", s_got, s_pop, ref_mem[3]); end
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) set_req(1'b1, 1'b0, 14'(c), 32'h0, 4'h0);
      else set_req(1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
      step();
      if (c < 16) begin
        n_cmp++; if (s_ready !== 1'b1 || s_acc !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected 1", c, s_ready); end
      end
      if (c > 0) begin
        n_cmp++; if (s_pop !== 1'b1 || s_got !== ref_mem[c-1]) begin n_err++; $display("FAIL b2b_rsp[%0d]: got %h pop %b expected %h pop 1", c, s_got, s_pop, ref_mem[c-1]); end
      end
    end
  endtask

  task automatic test_random();
    logic        prev_stall;
    logic [31:0] prev_got;
    prev_stall = 1'b0;
    prev_got   = '0;
    for (int c = 0; c < 340; c++) begin
      if (c < 40) begin
        bus.rsp_ready = (c % 2 == 0);
        if (!bus.req_valid || s_acc) set_req(1'b1, 1'b0, 14'($urandom_range(0, 15)), 32'h0, 4'h0);
      end else begin
        bus.rsp_ready = ($urandom_range(0, 2) != 0);
        if (!bus.req_valid || s_acc)
          set_req(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(0, 15)));
      end
      step();
      n_cmp++; if (s_ready !== (s_out < 2)) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, s_ready, (s_out < 2)); end
      n_cmp++; if (s_valid !== (s_out != 0)) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, s_valid, (s_out != 0)); end
      if (s_pop) begin
        n_cmp++; if (s_under || s_got !== s_exp) begin n_err++; $display("FAIL rnd_data[%0d]: got %h expected %h (empty %b)", c, s_got, s_exp, s_under); end
      end
      if (prev_stall) begin
        n_cmp++; if (s_got !== prev_got) begin n_err++; $display("FAIL rnd_stable[%0d]: got %h expected %h", c, s_got, prev_got); end
      end
      n_cmp++; if (exp_q.size() > 2) begin n_err++; $display("FAIL rnd_outstanding[%0d]: got %0d expected <=2", c, exp_q.size()); end
      prev_stall = s_valid && !bus.rsp_ready;
      prev_got   = s_got;
    end
    set_req(1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (s_pop) begin
        n_cmp++; if (s_under || s_got !== s_exp) begin n_err++; $display("FAIL drain_data[%0d]: got %h expected %h", c, s_got, s_exp); end
      end
    end
    n_cmp++; if (exp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %0d owed valid %b expected 0 owed valid 0", exp_q.size(), bus.rsp_valid); end
  endtask

  task automatic test_reset_midop();
    int acc_n;
    logic [31:0] wd;
    wd = $urandom;
    acc_n = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5 && acc_n < 2; c++) begin
      if (acc_n == 0) set_req(1'b1, 1'b1, 14'd20, wd, 4'hF);
      else set_req(1'b1, 1'b0, 14'd21, 32'h0, 4'h0);
      step();
      if (s_acc) acc_n++;
    end
    n_cmp++; if (acc_n != 2) begin n_err++; $display("FAIL midop_fill: got %0d expected 2", acc_n); end
    set_req(1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL midop_async: got valid %b ready %b expected 0 0", bus.rsp_valid, bus.req_ready); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    n_cmp++; if (s_ready !== 1'b1 || s_valid !== 1'b0) begin n_err++; $display("FAIL midop_release: got ready %b valid %b expected 1 0", s_ready, s_valid); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL midop_stale[%0d]: got %b expected 0", c, s_valid); end
    end
    set_req(1'b1, 1'b0, 14'd20, 32'h0, 4'h0);
    step();
    set_req(1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    step();
    n_cmp++; if (s_pop !== 1'b1 || s_got !== wd) begin n_err++; $display("FAIL midop_write_kept: got %h pop %b expected %h pop 1", s_got, s_pop, wd); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    s_acc = 1'b0;
    set_req(1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
